spi_master_cfg: RTL
===================

# spi_master_cfg

Parametrised SPI master that succeeds the fixed 8-bit, single-slave, clock-rate master/slave pair. It adds:
- configurable word width and bit order;
- all four CPOL/CPHA modes;
- a programmable SCLK divider;
- multiple one-hot chip selects;
- a start/busy/done handshake toward the host logic.

It sits between a local controller and the off-chip SPI pins.

## Interface
- DATA_W, 8: bits per transfer (≥2).
- NUM_CS, 4: number of chip-select lines (≥1); SEL_W = max(1, clog2(NUM_CS)).
- DIV_W, 8: width of clk_div.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  request a transfer; accepted only when busy=0.
- tx_data  in  DATA_W  word to send; latched on accept.
- cs_sel  in  SEL_W  slave index; latched on accept.
- cpol, cpha  in  1 each  SPI mode; latched on accept.
- lsb_first  in  1  bit order (0 = MSB first); latched on accept.
- clk_div  in  DIV_W  SCLK half-period minus one, in clk cycles; latched on accept.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse; rx_data valid from this cycle.
- rx_data  out  DATA_W  received word; held until next done.
- sclk  out  1  SPI clock, registered.
- mosi  out  1  serial out, registered.
- miso  in  1  serial in.
- cs_n  out  NUM_CS  active-low selects; at most one low.

## Operation
- **Reset values:** sclk=0, mosi=0, cs_n=all ones, busy=0, done=0, rx_data=0, state IDLE, latched config 0.
- **Half-period:** H = clk_div+1 clk cycles.
- **IDLE**
  - sclk is registered from the cpol input every cycle.
  - On start=1: latch config and tx_data into the shift register; go to SETUP.
- **SETUP** (H cycles)
  - busy=1; cs_n[cs_sel]=0.
  - If cs_sel ≥ NUM_CS, no line is asserted, but the transfer still runs and done still pulses.
  - CPHA=0: mosi = first bit, driven on SETUP entry.
- **SHIFT** (2·DATA_W half-periods)
  - Each half-period end toggles sclk. Edges alternate leading/trailing, starting with leading.
  - CPHA=0: leading edge samples miso; trailing edge drives the next bit. There is no drive after the last trailing edge.
  - CPHA=1: leading edge drives a bit (first bit on the first leading edge); trailing edge samples.
  - miso is captured at the clk edge that produces the sampling sclk transition.
- **HOLD** (H cycles): sclk=cpol; select still asserted.
- **Completion:** next cycle done=1, busy=0, cs_n=all ones, rx_data updated; return to IDLE.
- **Bit order:** lsb_first=1 sends tx_data[0] first and places the first received bit in rx_data[0]. Otherwise MSB first both ways.
- **Mid-transfer changes:** config inputs changed mid-transfer have no effect. start while busy=1 is ignored (not queued).

## Timing
- **Accept:** start sampled at edge 0 → busy=1 and cs_n asserted after edge 1.
- **done:** high for exactly one cycle, after edge 1 + H·(2·DATA_W+2). Latency from start to done = H·(2·DATA_W+2)+1 cycles.
- **SCLK edges:** exactly 2·DATA_W per transfer; sclk duty 50%.
- **Back-to-back:** start asserted during the done cycle is accepted. cs_n stays high for exactly that one cycle, so the minimum deselect time is 1 clk.
- **Reset mid-transfer:** all outputs take reset values immediately (asynchronous). No done pulse; partial rx_data is discarded.
- **clk_div=0:** sclk = clk/2.
- **clk_div = max:** H = 2^DIV_W with no overflow; the internal counter is DIV_W bits and counts 0..clk_div.

## Test plan
- **Loopback, mode 0:** mosi→miso, DATA_W=8, clk_div=0, tx=0xA5, cs_sel=2.
  - Expect: cs_n=4'b1011 during the transfer; 16 sclk edges; done 19 cycles after start; rx_data=0xA5.
- **Mode 3:** slave model returns 0x3C, clk_div=3, tx=0xC3.
  - Expect: sclk idles high; mosi changes only on falling edges; done 73 cycles after start; rx=0x3C; slave model receives 0xC3.
- **LSB-first, mode 1:** tx=0x01 with loopback.
  - Expect: first mosi bit =1; rx_data=0x01.
- **Handshake:** start pulsed again mid-transfer, then start held through the done cycle.
  - Expect: second pulse ignored; the held start begins the next transfer with a 1-cycle cs_n-high gap.
- **Abort:** reset asserted after 5 sclk edges.
  - Expect: cs_n=all ones, sclk=0, busy=0 immediately; no done; the next transfer completes correctly.
- **Out-of-range select:** DATA_W=16, NUM_CS=3, cs_sel=3.
  - Expect: no cs_n low; 32 sclk edges; done pulses.

Source files
------------

// File: rtl/spi_master_cfg.sv
// SPI master with configurable width, bit order, CPOL/CPHA mode, SCLK divider
// and one-hot chip selects, driven by a start/busy/done handshake.
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                half_end;
    logic                sample_edge;
    logic                tx_bit;
    logic [NUM_CS-1:0]   cs_dec;

    assign half_end    = (cnt_q == div_q);
    // Even edge index = leading edge; CPHA=0 samples on leading, CPHA=1 on trailing.
    assign sample_edge = (~edge_q[0]) ^ cpha_q;
    assign tx_bit      = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        edge_d    = edge_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Out-of-range selects match no line, so every cs_n stays high.
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (cs_sel != SEL_W'(i));
        end

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    div_d   = clk_div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    rx_sh_d = '0;
                    busy_d  = 1'b1;
                    cs_n_d  = cs_dec;
                    if (cpha) begin
                        tx_sh_d = tx_data;
                    end else begin
                        mosi_d  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                        tx_sh_d = lsb_first ? (tx_data >> 1) : (tx_data << 1);
                    end
                end
            end
            SETUP: begin
                if (half_end) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (sample_edge) begin
                        rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]}
                                        : {rx_sh_q[DATA_W-2:0], miso};
                    end else if (cpha_q || (edge_q != LAST_EDGE)) begin
                        mosi_d  = tx_bit;
                        tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                    end
                    if (edge_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                sclk_d = cpol_q;
                if (half_end) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cs_n_d    = '1;
                    rx_data_d = rx_sh_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule
